fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_32im_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_32im_pkg.sv
// Shared types and memory-map constants for the RV32IM core front end.
package riscv_32im_pkg;

   localparam logic [31:0] MAP_IMEM_BASE = 32'h0000_0000;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StFault = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fetch_err;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch packets; flush empties it, and a push in the
// same cycle as a flush becomes the sole entry.
module fetch_fifo
   import riscv_32im_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  fetch_pkt_t                   push_pkt_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic [$clog2(Depth+1)-1:0]   count_o,
   output fetch_pkt_t                   head_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   fetch_pkt_t            mem_q [Depth];
   fetch_pkt_t            mem_d [Depth];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;

   // Wrap explicitly so non-power-of-two depths still work.
   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         if (push_i) begin
            mem_d[0] = push_pkt_i;
            wr_ptr_d = ptr_inc('0);
            count_d  = CntW'(1);
         end
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = push_pkt_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
         end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential imem requests, response buffering
// for decode, and trap/redirect retargeting with misaligned-target fault packets.
module fetch_unit
   import riscv_32im_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = MAP_IMEM_BASE,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        trap_valid_i,
   input  logic [31:0] trap_pc_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_valid_o,
   output logic        imem_ready_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_instr_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o,
   output logic        id_fetch_err_o,
   input  logic        id_ready_i
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e    state_q, state_d;
   logic [31:0]     pc_q, pc_d, inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;
   logic            redir, redir_misaligned, credit_ok, issue, push, pop;
   logic [31:0]     redir_pc, occupancy;
   logic [CntW-1:0] count;
   fetch_pkt_t      push_pkt, head_pkt;

   // Trap wins over a branch redirect.
   assign redir            = trap_valid_i | redirect_valid_i;
   assign redir_pc         = trap_valid_i ? trap_pc_i : redirect_pc_i;
   assign redir_misaligned = redir_pc[1:0] != 2'b00;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StRun;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
      if (redir) begin
         state_d = redir_misaligned ? StFault : StRun;
         pc_d    = redir_pc;
      end else if (issue) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_comb begin
      // Responses already in flight still hold a slot, so count them against the buffer.
      occupancy    = 32'(count) + 32'(inflight_q) - 32'(pop);
      credit_ok    = occupancy < FIFO_DEPTH;
      // Gating with rst_ni keeps the request low while reset is held.
      imem_valid_o = rst_ni && (state_q == StRun) && !redir && credit_ok;
      imem_ready_o = imem_valid_o;
      issue        = imem_valid_o && imem_ready_o;
      imem_addr_o  = pc_q;

      id_valid_o     = count != '0;
      id_pc_o        = head_pkt.pc;
      id_instr_o     = head_pkt.instr;
      id_fetch_err_o = head_pkt.fetch_err;
      pop            = id_valid_o && id_ready_i;

      if (redir) begin
         push     = redir_misaligned;
         push_pkt = '{pc: redir_pc, instr: 32'h0, fetch_err: 1'b1};
      end else begin
         push     = inflight_q && imem_valid_i;
         push_pkt = '{pc: inflight_pc_q, instr: imem_instr_i, fetch_err: 1'b0};
      end
   end

   fetch_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push),
      .push_pkt_i (push_pkt),
      .pop_i      (pop),
      .flush_i    (redir),
      .count_o    (count),
      .head_o     (head_pkt)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected issues/packets, a negedge
// monitor pops and compares them and also applies per-cycle directed expectations.
module tb_fetch_unit;
   import riscv_32im_pkg::*;

   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        trap_valid_i, redirect_valid_i;
   logic [31:0] trap_pc_i, redirect_pc_i;
   logic        imem_valid_o, imem_ready_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i = 1'b0;
   logic [31:0] imem_instr_i = '0;
   logic        id_valid_o, id_fetch_err_o, id_ready_i;
   logic [31:0] id_pc_o, id_instr_o;

   fetch_unit #(
      .RESET_PC   (ResetPc),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .trap_valid_i     (trap_valid_i),
      .trap_pc_i        (trap_pc_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_valid_o     (imem_valid_o),
      .imem_ready_o     (imem_ready_o),
      .imem_addr_o      (imem_addr_o),
      .imem_valid_i     (imem_valid_i),
      .imem_instr_i     (imem_instr_i),
      .id_valid_o       (id_valid_o),
      .id_pc_o          (id_pc_o),
      .id_instr_o       (id_instr_o),
      .id_fetch_err_o   (id_fetch_err_o),
      .id_ready_i       (id_ready_i)
   );

   always #5 clk_i = ~clk_i;

   // imem model: one-cycle latency, instr = ~addr, valid held high after a response.
   always @(posedge clk_i) begin
      if (!rst_ni) begin
         imem_valid_i <= 1'b0;
      end else if (imem_valid_o && imem_ready_o) begin
         imem_valid_i <= 1'b1;
         imem_instr_i <= ~imem_addr_o;
      end
   end

   logic [31:0] exp_issue_q[$];
   fetch_pkt_t  exp_pkt_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // Per-cycle directed expectations set by the stimulus (-1 = don't care).
   int          exp_iv = -1;
   int          exp_idv = -1;
   bit          chk_idpc = 1'b0;
   logic [31:0] exp_idpc = '0;
   bit          chk_rst = 1'b0;
   bit          chk_end = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         if (chk_rst) begin
            chk("rst_imem_valid", 32'(imem_valid_o), 32'd0);
            chk("rst_imem_ready", 32'(imem_ready_o), 32'd0);
            chk("rst_imem_addr", imem_addr_o, ResetPc);
            chk("rst_id_valid", 32'(id_valid_o), 32'd0);
            chk("rst_id_pc", id_pc_o, 32'd0);
            chk("rst_id_instr", id_instr_o, 32'd0);
            chk("rst_id_err", 32'(id_fetch_err_o), 32'd0);
         end
      end else begin
         if (imem_valid_o && imem_ready_o) begin
            if (exp_issue_q.size() == 0) chk("issue_unexpected", imem_addr_o, 32'hxxxx_xxxx);
            else chk("issue_addr", imem_addr_o, exp_issue_q.pop_front());
         end
         if (id_valid_o && id_ready_i) begin
            if (exp_pkt_q.size() == 0) begin
               chk("pkt_unexpected", id_pc_o, 32'hxxxx_xxxx);
            end else begin
               fetch_pkt_t e;
               e = exp_pkt_q.pop_front();
               chk("pkt_pc", id_pc_o, e.pc);
               chk("pkt_instr", id_instr_o, e.instr);
               chk("pkt_err", 32'(id_fetch_err_o), 32'(e.fetch_err));
            end
         end
         if (exp_iv >= 0) begin
            chk("imem_valid", 32'(imem_valid_o), 32'(exp_iv));
            chk("imem_ready", 32'(imem_ready_o), 32'(exp_iv));
         end
         if (exp_idv >= 0) chk("id_valid", 32'(id_valid_o), 32'(exp_idv));
         if (chk_idpc) chk("id_pc_hold", id_pc_o, exp_idpc);
         if (chk_end) begin
            chk("issue_q_left", 32'(exp_issue_q.size()), 32'd0);
            chk("pkt_q_left", 32'(exp_pkt_q.size()), 32'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
      exp_iv   = -1;
      exp_idv  = -1;
      chk_idpc = 1'b0;
      chk_rst  = 1'b0;
      chk_end  = 1'b0;
   endtask

   task automatic exp_issue(logic [31:0] base, int n);
      for (int i = 0; i < n; i++) exp_issue_q.push_back(base + 32'(4 * i));
   endtask

   task automatic exp_pkts(logic [31:0] base, int n);
      for (int i = 0; i < n; i++) begin
         exp_pkt_q.push_back('{pc: base + 32'(4 * i), instr: ~(base + 32'(4 * i)),
                               fetch_err: 1'b0});
      end
   endtask

   initial begin
      rst_ni = 1'b1;
      id_ready_i = 1'b0;
      trap_valid_i = 1'b0;
      trap_pc_i = '0;
      redirect_valid_i = 1'b0;
      redirect_pc_i = '0;
      #1 rst_ni = 1'b0;
      cyc(); chk_rst = 1'b1;
      // Cycle 0: release; first issue must be this cycle.
      exp_issue(32'h0, 8); exp_pkts(32'h0, 6);
      cyc(); rst_ni = 1'b1; id_ready_i = 1'b1; exp_iv = 1; exp_idv = 0;
      cyc(); exp_idv = 0;
      cyc(); exp_idv = 1; chk_idpc = 1'b1; exp_idpc = 32'h0;
      repeat (5) cyc();
      // Cycles 8..12: decode stalls; buffer fills to 2 and head 0x18 holds.
      cyc(); id_ready_i = 1'b0; exp_iv = 0;
      repeat (4) begin
         cyc(); exp_iv = 0; exp_idv = 1; chk_idpc = 1'b1; exp_idpc = 32'h18;
      end
      exp_issue(32'h20, 4); exp_pkts(32'h18, 4);
      cyc(); id_ready_i = 1'b1;
      repeat (3) cyc();
      // Branch redirect with 0x28 buffered and 0x2c in flight: both dropped.
      exp_issue(32'h100, 4); exp_pkts(32'h100, 2);
      cyc(); id_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h100; exp_iv = 0;
      cyc(); redirect_valid_i = 1'b0; id_ready_i = 1'b1; exp_idv = 0; exp_iv = 1;
      repeat (3) cyc();
      // Trap and redirect together: trap target wins.
      exp_issue(32'h200, 4); exp_pkts(32'h200, 2);
      cyc(); id_ready_i = 1'b0; trap_valid_i = 1'b1; trap_pc_i = 32'h200;
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h100; exp_iv = 0;
      cyc(); trap_valid_i = 1'b0; redirect_valid_i = 1'b0; id_ready_i = 1'b1; exp_iv = 1;
      repeat (3) cyc();
      // Misaligned redirect: one fault packet, then no fetch until a trap.
      exp_pkt_q.push_back('{pc: 32'h102, instr: 32'h0, fetch_err: 1'b1});
      cyc(); id_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h102; exp_iv = 0;
      cyc(); redirect_valid_i = 1'b0; id_ready_i = 1'b1; exp_iv = 0; exp_idv = 1;
      chk_idpc = 1'b1; exp_idpc = 32'h102;
      repeat (3) begin
         cyc(); exp_iv = 0; exp_idv = 0;
      end
      exp_issue(32'h40, 4); exp_pkts(32'h40, 2);
      cyc(); trap_valid_i = 1'b1; trap_pc_i = 32'h40; id_ready_i = 1'b0; exp_iv = 0;
      cyc(); trap_valid_i = 1'b0; id_ready_i = 1'b1; exp_iv = 1;
      repeat (3) cyc();
      // Mid-cycle reset pulse with 0x48 buffered and 0x4c in flight.
      cyc(); id_ready_i = 1'b0; #1 rst_ni = 1'b0; chk_rst = 1'b1;
      exp_issue(ResetPc, 6); exp_pkts(ResetPc, 4);
      cyc(); rst_ni = 1'b1; id_ready_i = 1'b1; exp_iv = 1;
      repeat (5) cyc();
      cyc(); id_ready_i = 1'b0; exp_iv = 0;
      cyc(); chk_end = 1'b1;
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
